// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for piso_frame_tx.
// The master side feeds words in. The slave side (the transmitter) drives the serial output and status.
interface piso_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data,
        input  in_ready, so, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, so, busy, done
    );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter.
// Frame format: start(1), data MSB-first, optional even parity, stop(0).
module piso_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input logic             clk,
    input logic             rst_n,
    piso_frame_tx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             so_q;
    logic             handshake;

    assign handshake = bus.in_valid & bus.in_ready;

    // so is registered. Each branch therefore loads the bit that belongs to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            so_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_STOP: begin
                    if (handshake) begin
                        state <= S_START;
                        shreg <= bus.in_data;
                        par   <= ^bus.in_data;
                        so_q  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        so_q  <= 1'b0;
                    end
                end
                S_START: begin
                    state <= S_DATA;
                    cnt   <= CW'(WIDTH - 1);
                    so_q  <= shreg[WIDTH-1];
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        if (PARITY_EN != 0) begin
                            state <= S_PARITY;
                            so_q  <= par;
                        end else begin
                            state <= S_STOP;
                            so_q  <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt - CW'(1);
                        so_q  <= shreg[WIDTH-1];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end
                end
                S_PARITY: begin
                    state <= S_STOP;
                    so_q  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    so_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = (state == S_IDLE) || (state == S_STOP);
    assign bus.busy     = (state == S_START) || (state == S_DATA) || (state == S_PARITY);
    assign bus.done     = (state == S_STOP);
    assign bus.so       = so_q;
endmodule

// File: tb/tb_piso_frame_tx.sv
// Testbench for piso_frame_tx, with and without parity.
// Each DUT is compared cycle by cycle against a queue of expected frame symbols.
module tb_piso_frame_tx;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_frame_tx_if #(.WIDTH(8)) bus_p ();
    piso_frame_tx_if #(.WIDTH(8)) bus_n ();

    piso_frame_tx #(.WIDTH(8), .PARITY_EN(1)) dut_p (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p)
    );

    piso_frame_tx #(.WIDTH(8), .PARITY_EN(0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    // Expected symbol per cycle, packed as {in_ready, busy, done, so}.
    localparam logic [3:0] E_IDLE = 4'b1000;
    logic [3:0] q_p[$];
    logic [3:0] q_n[$];
    logic [3:0] cur_p = E_IDLE;
    logic [3:0] cur_n = E_IDLE;

    int checks   = 0;
    int failures = 0;

    logic [21:0] got_so;
    logic [21:0] got_done;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int evenParity(input logic [7:0] w);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        return ones % 2;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then check both DUTs.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        logic hs_p;
        logic hs_n;
        int   p;
        rst_n          = r;
        bus_p.in_valid = v;
        bus_p.in_data  = d;
        bus_n.in_valid = v;
        bus_n.in_data  = d;
        hs_p = r && v && cur_p[3];
        hs_n = r && v && cur_n[3];
        p    = evenParity(d);
        @(posedge clk);
        if (!r) begin
            q_p.delete();
            q_n.delete();
        end else begin
            if (hs_p) begin
                q_p.push_back(4'b0101);
                for (int i = 7; i >= 0; i--) q_p.push_back({3'b010, d[i]});
                q_p.push_back({3'b010, p[0]});
                q_p.push_back(4'b1010);
            end
            if (hs_n) begin
                q_n.push_back(4'b0101);
                for (int i = 7; i >= 0; i--) q_n.push_back({3'b010, d[i]});
                q_n.push_back(4'b1010);
            end
        end
        if (q_p.size() > 0) cur_p = q_p.pop_front();
        else                cur_p = E_IDLE;
        if (q_n.size() > 0) cur_n = q_n.pop_front();
        else                cur_n = E_IDLE;
        @(negedge clk);
        checkOutput("par_outputs",   {28'd0, bus_p.in_ready, bus_p.busy, bus_p.done, bus_p.so}, {28'd0, cur_p});
        checkOutput("nopar_outputs", {28'd0, bus_n.in_ready, bus_n.busy, bus_n.done, bus_n.so}, {28'd0, cur_n});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_p.in_valid = 1'b0;
        bus_p.in_data  = '0;
        bus_n.in_valid = 1'b0;
        bus_n.in_data  = '0;

        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        idleCycles(2);

        // Single parity frame of A5
        applyStimulus(1'b1, 8'hA5, 1'b1);
        got_so = '0; got_done = '0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) applyStimulus(1'b0, 8'h00, 1'b1);
            got_so   = {got_so[20:0], bus_p.so};
            got_done = {got_done[20:0], bus_p.done};
        end
        checkOutput("a5_so",   {21'd0, got_so[10:0]},   {21'd0, 11'b1_10100101_0_0});
        checkOutput("a5_done", {21'd0, got_done[10:0]}, {21'd0, 11'b0000000000_1});
        idleCycles(3);

        // Back-to-back 01 then FF; in_data switches to FF right after the first handshake
        applyStimulus(1'b1, 8'h01, 1'b1);
        got_so = '0;
        got_so = {got_so[20:0], bus_p.so};
        for (int i = 1; i < 22; i++) begin
            applyStimulus(i <= 11, 8'hFF, 1'b1);
            got_so = {got_so[20:0], bus_p.so};
        end
        checkOutput("b2b_so", {10'd0, got_so}, {10'd0, 22'b1_00000001_1_0_1_11111111_0_0});
        idleCycles(3);

        // Valid held with toggling data while the frame is in flight
        applyStimulus(1'b1, 8'h6E, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
        idleCycles(4);

        // Reset during the 4th data bit aborts both frames
        applyStimulus(1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        idleCycles(12);

        // No-parity frame of 80
        applyStimulus(1'b1, 8'h80, 1'b1);
        got_so = '0; got_done = '0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) applyStimulus(1'b0, 8'h00, 1'b1);
            got_so   = {got_so[20:0], bus_n.so};
            got_done = {got_done[20:0], bus_n.done};
        end
        checkOutput("np80_so",   {22'd0, got_so[9:0]},   {22'd0, 10'b1_10000000_0});
        checkOutput("np80_done", {22'd0, got_done[9:0]}, {22'd0, 10'b000000000_1});
        idleCycles(3);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 3) != 0, 8'($urandom), ($urandom % 150) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_frame_tx.md
PISO_FRAME_TX -- requirements
Module: piso_frame_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter PARITY_EN, default 1: when set, the block SHALL insert an even-parity bit after the data bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream asserts that in_data holds a word to transmit.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 so  output  1  registered serial line output; the serial-in of a downstream shift-register receiver connects here.
REQ-009 busy  output  1  high while a frame is in progress, covering START through PARITY.
REQ-010 done  output  1  one-cycle pulse marking the stop-bit cycle of a completed frame.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY and STOP; PARITY SHALL be unreachable when PARITY_EN=0.
REQ-012 Handshake SHALL occur on any rising edge with in_valid=1 and in_ready=1; in_data is captured into the shift register only at that edge.
REQ-013 in_ready SHALL be 1 in IDLE and STOP and 0 in all other states; in_valid SHALL be ignored while in_ready=0.
REQ-014 IDLE: so=0, busy=0, done=0; a handshake SHALL move the block to START at the same edge.
REQ-015 START: so=1 (start bit) for exactly one cycle; the next state SHALL be DATA with the bit counter set to WIDTH-1.
REQ-016 DATA: so SHALL carry the captured word MSB-first, one bit per cycle, for exactly WIDTH cycles; the counter SHALL decrement each cycle, and the next state after count 0 SHALL be PARITY (PARITY_EN=1) or STOP.
REQ-017 PARITY: so SHALL equal the XOR of all captured data bits (even parity) for one cycle, then the next state SHALL be STOP.
REQ-018 STOP: so=0, done=1, busy=0 for one cycle; the next state SHALL be START on a handshake in this cycle, otherwise IDLE.
REQ-019 Latency: the start bit SHALL appear on so in the cycle immediately after the handshake edge.
REQ-020 Frame length SHALL be 1+WIDTH+PARITY_EN+1 cycles, and back-to-back frames SHALL have zero idle cycles between them.
REQ-021 Changes on in_data after the handshake SHALL have no effect on the frame in progress.
REQ-022 done SHALL never assert for an aborted frame, and SHALL never be high for two consecutive cycles.

Reset
REQ-023 On any edge with rst_n=0: state=IDLE, so=0, busy=0, done=0, in_ready=1, and shift register and counter cleared.
REQ-024 Reset SHALL take priority over any handshake in the same cycle; a mid-frame reset SHALL abort the frame with no further frame bits driven on so.
REQ-025 Reset SHALL be deasserted synchronously; the first handshake SHALL be accepted on the first edge with rst_n=1.

Verification (WIDTH=8 unless noted)
REQ-026 Reset: rst_n=0 for 2 cycles -> so=0, in_ready=1, busy=0, done=0.
REQ-027 Single frame: PARITY_EN=1, handshake of 8'hA5 -> so over the following 11 cycles = 1, 1,0,1,0,0,1,0,1, 0, 0; done=1 only in the 11th cycle.
REQ-028 Back-to-back: 8'h01 then 8'hFF with in_valid held -> second word accepted in the STOP cycle of the first; so = 1,00000001,1,0, 1,11111111,0,0 with no gap.
REQ-029 Busy guard: in_valid=1 with in_data toggling during DATA -> in_ready=0, transmitted bits unchanged, no extra frame sent.
REQ-030 Mid-frame reset: rst_n=0 during the 4th data bit -> next cycle so=0, state IDLE; done is never asserted for that frame.
REQ-031 PARITY_EN=0: handshake of 8'h80 -> so over the following 10 cycles = 1, 1,0,0,0,0,0,0,0, 0; done=1 in the 10th cycle.
